// File: rtl/hack_alu_ctrl.sv
// Multi-cycle sequencer for the 16-bit Hack ALU.
// Holds the A, D and M registers, the instruction register and the PC.
// It fetches one instruction at a time, fetches the M operand through a
// read handshake when the instruction needs it, and then executes it in a
// single cycle against the external combinational ALU.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | instr_ready high; A-instructions complete here in one cycle
// WAIT_M   | read_m high at address A until in_m_valid latches M
// EXEC     | ALU driven from IR; dest/write/jump applied at the clock edge
module hack_alu_ctrl #(
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [15:0]     instr,
    output logic            instr_ready,
    output logic            read_m,
    input  logic [15:0]     in_m,
    input  logic            in_m_valid,
    output logic            alu_zx,
    output logic            alu_nx,
    output logic            alu_zy,
    output logic            alu_ny,
    output logic            alu_f,
    output logic            alu_no,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    input  logic [15:0]     alu_out,
    output logic [15:0]     out_m,
    output logic            write_m,
    output logic [PC_W-1:0] address_m,
    output logic [PC_W-1:0] pc
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT_M = 2'd1,
        ST_EXEC   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     d_q, d_d;
    logic [15:0]     m_q, m_d;
    logic [15:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic [5:0]      ctrl;
    logic            ready_raw;
    logic            zr;
    logic            ng;
    logic            jump;
    logic [PC_W-1:0] pc_inc;

    // Opcode prefix bits of IR carry no information once the state is known.
    logic            ir_unused;
    assign ir_unused = &{1'b0, ir_q[15:13]};

    assign zr     = (alu_out == 16'h0000);
    assign ng     = alu_out[15];
    assign jump   = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);
    assign pc_inc = pc_q + PC_W'(1);

    // Register file: everything returns to its reset value at once on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            a_q     <= 16'h0000;
            d_q     <= 16'h0000;
            m_q     <= 16'h0000;
            ir_q    <= 16'h0000;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            m_q     <= m_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state and output decode for the fetch / M-read / execute sequence.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        d_d       = d_q;
        m_d       = m_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        ready_raw = 1'b0;
        read_m    = 1'b0;
        write_m   = 1'b0;
        out_m     = 16'h0000;
        ctrl      = 6'b000000;

        case (state_q)
            ST_FETCH: begin
                ready_raw = 1'b1;
                if (instr_valid) begin
                    ir_d = instr;
                    if (!instr[15]) begin
                        a_d  = instr;
                        pc_d = pc_inc;
                    end else if (instr[12]) begin
                        state_d = ST_WAIT_M;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_WAIT_M: begin
                read_m = 1'b1;
                if (in_m_valid) begin
                    m_d     = in_m;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                ctrl = ir_q[11:6];
                if (ir_q[4]) begin
                    d_d = alu_out;
                end
                if (ir_q[5]) begin
                    a_d = alu_out;
                end
                if (ir_q[3]) begin
                    write_m = 1'b1;
                    out_m   = alu_out;
                end
                // Jump target is the A value held before this instruction.
                pc_d    = jump ? a_q[PC_W-1:0] : pc_inc;
                state_d = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Keep instr_ready low while reset is held so no word is taken during reset.
    assign instr_ready = ready_raw & rst_n;

    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

    assign alu_x     = d_q;
    assign alu_y     = ir_q[12] ? m_q : a_q;
    assign address_m = a_q[PC_W-1:0];
    assign pc        = pc_q;

endmodule
